// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues in-order word reads for the current PC, buffers
// returned instructions with their PC for decode, and squashes in-flight work on redirect.
module ifetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  output logic        stay,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_r, state_n;
  logic [CW-1:0]   out_cnt_r, out_n;
  logic [CW-1:0]   drop_r, drop_n;
  logic [CW-1:0]   q_cnt_r;
  logic [AW-1:0]   q_wr_r, q_rd_r, t_wr_r, t_rd_r;
  logic [31:0]     q_instr_r [DEPTH];
  logic [31:0]     q_pc_r    [DEPTH];
  logic            q_mis_r   [DEPTH];
  logic [31:0]     t_pc_r    [DEPTH];
  logic            dec_valid_r, dec_mis_r;
  logic [31:0]     dec_instr_r, dec_pc_r;

  logic [CW-1:0]   occ_s;
  logic            pop_s, slot_free_s, can_fetch_s, aligned_s;
  logic            fetch_acc_s, mis_acc_s, rsp_take_s, rsp_in_s, clear_s;
  logic            push_s, load_s, fifo_pop_s, push_out_s, push_fifo_s;
  logic [31:0]     push_instr_s, push_pc_s;

  assign imem_addr    = {pc[31:2], 2'b00};
  assign dec_valid    = dec_valid_r;
  assign dec_instr    = dec_instr_r;
  assign dec_pc       = dec_pc_r;
  assign dec_misalign = dec_mis_r;

  // Credit accounting, fetch acceptance and queue routing decisions.
  always_comb begin
    pop_s       = dec_valid_r && dec_ready;
    occ_s       = out_cnt_r + q_cnt_r + CW'(dec_valid_r);
    slot_free_s = (occ_s < DEPTH_C) || ((occ_s == DEPTH_C) && pop_s);
    can_fetch_s = rstn && (state_r == RUN) && slot_free_s && !flush;
    aligned_s   = (pc[1:0] == 2'b00);
    imem_req_valid = can_fetch_s && aligned_s;
    fetch_acc_s = imem_req_valid && imem_req_ready;
    // A misaligned PC bypasses memory, so it must wait until older fetches have returned.
    mis_acc_s   = can_fetch_s && !aligned_s && (out_cnt_r == ZERO_C);
    stay        = !(fetch_acc_s || mis_acc_s);
    rsp_in_s    = imem_rsp_valid && (out_cnt_r != ZERO_C);
    rsp_take_s  = rsp_in_s && (state_r == RUN) && !flush;
    clear_s     = (state_r == RUN) && flush;
    push_s      = rsp_take_s || mis_acc_s;
    if (mis_acc_s) begin
      push_instr_s = NOP_INSTR;
      push_pc_s    = pc;
    end else begin
      push_instr_s = imem_rsp_data;
      push_pc_s    = t_pc_r[t_rd_r];
    end
    load_s      = !dec_valid_r || pop_s;
    fifo_pop_s  = load_s && (q_cnt_r != ZERO_C);
    push_out_s  = push_s && load_s && (q_cnt_r == ZERO_C);
    push_fifo_s = push_s && !push_out_s;
  end

  // FSM next state plus outstanding/drop counter updates.
  always_comb begin
    state_n = state_r;
    out_n   = out_cnt_r;
    drop_n  = drop_r;
    case (state_r)
      RUN: begin
        if (flush) begin
          out_n  = ZERO_C;
          drop_n = out_cnt_r - CW'(rsp_in_s);
          if (drop_n != ZERO_C) state_n = DRAIN;
          else                  state_n = RUN;
        end else begin
          out_n = out_cnt_r + CW'(fetch_acc_s) - CW'(rsp_take_s);
        end
      end
      DRAIN: begin
        if (imem_rsp_valid && (drop_r != ZERO_C)) drop_n = drop_r - ONE_C;
        else                                       drop_n = drop_r;
        if (drop_n == ZERO_C) state_n = RUN;
        else                  state_n = DRAIN;
      end
      default: begin
        state_n = RUN;
        out_n   = ZERO_C;
        drop_n  = ZERO_C;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= RUN;
      out_cnt_r <= ZERO_C;
      drop_r    <= ZERO_C;
    end else begin
      state_r   <= state_n;
      out_cnt_r <= out_n;
      drop_r    <= drop_n;
    end
  end

  // Queue pointers and the registered decode head.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_cnt_r     <= ZERO_C;
      q_wr_r      <= AW'(0);
      q_rd_r      <= AW'(0);
      t_wr_r      <= AW'(0);
      t_rd_r      <= AW'(0);
      dec_valid_r <= 1'b0;
      dec_instr_r <= 32'h0000_0000;
      dec_pc_r    <= 32'h0000_0000;
      dec_mis_r   <= 1'b0;
    end else if (clear_s) begin
      q_cnt_r     <= ZERO_C;
      q_wr_r      <= AW'(0);
      q_rd_r      <= AW'(0);
      t_wr_r      <= AW'(0);
      t_rd_r      <= AW'(0);
      dec_valid_r <= 1'b0;
    end else begin
      if (fetch_acc_s) t_wr_r <= t_wr_r + AW'(1);
      if (rsp_take_s)  t_rd_r <= t_rd_r + AW'(1);
      if (push_fifo_s) q_wr_r <= q_wr_r + AW'(1);
      if (fifo_pop_s)  q_rd_r <= q_rd_r + AW'(1);
      q_cnt_r <= q_cnt_r + CW'(push_fifo_s) - CW'(fifo_pop_s);
      // The head register refills from the backlog first, else straight from the new entry.
      if (load_s) begin
        if (q_cnt_r != ZERO_C) begin
          dec_valid_r <= 1'b1;
          dec_instr_r <= q_instr_r[q_rd_r];
          dec_pc_r    <= q_pc_r[q_rd_r];
          dec_mis_r   <= q_mis_r[q_rd_r];
        end else if (push_s) begin
          dec_valid_r <= 1'b1;
          dec_instr_r <= push_instr_s;
          dec_pc_r    <= push_pc_s;
          dec_mis_r   <= mis_acc_s;
        end else begin
          dec_valid_r <= 1'b0;
        end
      end
    end
  end

  // Storage arrays for the PC tag FIFO and the instruction backlog.
  always_ff @(posedge clk) begin
    if (fetch_acc_s) t_pc_r[t_wr_r] <= pc;
    if (push_fifo_s) begin
      q_instr_r[q_wr_r] <= push_instr_s;
      q_pc_r[q_wr_r]    <= push_pc_s;
      q_mis_r[q_wr_r]   <= mis_acc_s;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue with a fixed-latency in-order memory model
// and a PC unit that advances by 4 on every accepted cycle.
module tb_ifetch_queue;

  localparam logic [31:0] DKEY = 32'hDEAD0000;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstn, stay, flush;
  logic [31:0] pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready, dec_misalign;
  logic [31:0] dec_instr, dec_pc;

  typedef struct {int due; logic [31:0] addr;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic mis; int cyc;} pop_t;

  mreq_t       mq[$];
  pop_t        pops[$];
  logic [31:0] reqs[$];
  int          req_cyc[$];
  int          ncyc = 0;
  int          lat  = 1;
  int          n_checks = 0;
  int          n_fail   = 0;

  ifetch_queue #(.DEPTH(4), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .stay(stay), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_misalign(dec_misalign)
  );

  always #5 clk = ~clk;

  // Memory model and monitors, sampled mid-cycle when all inputs are stable.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (rstn !== 1'b1) begin
      mq.delete();
      pops.delete();
      reqs.delete();
      req_cyc.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{ncyc + lat, imem_addr});
        reqs.push_back(imem_addr);
        req_cyc.push_back(ncyc);
      end
      if (dec_valid && dec_ready) pops.push_back('{dec_pc, dec_instr, dec_misalign, ncyc});
      if (mq.size() > 0 && mq[0].due == ncyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr ^ DKEY;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic cycle();
    logic acc;
    @(negedge clk);
    acc = (stay === 1'b0);
    @(posedge clk);
    #1;
    if (acc) pc = pc + 32'd4;
    #1;
  endtask

  task automatic do_reset(input int l);
    rstn = 1'b0; flush = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1; pc = 32'h0; lat = l;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1; pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (stay !== 1'b1) begin n_fail++; $display("FAIL reset_stay: got %b expected 1", stay); end
    n_checks++; if (dec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_dec_instr: got %h expected 0", dec_instr); end
    n_checks++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_dec_pc: got %h expected 0", dec_pc); end
    n_checks++; if (dec_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_dec_misalign: got %b expected 0", dec_misalign); end
  endtask

  task automatic test_stream();
    do_reset(1);
    repeat (12) cycle();
    n_checks++; if (stay !== 1'b0) begin n_fail++; $display("FAIL stream_stay: got %b expected 0", stay); end
    n_checks++;
    if (pops.size() < 8 || req_cyc.size() < 1) begin
      n_fail++; $display("FAIL stream_count: got %0d pops expected at least 8", pops.size());
    end else begin
      n_checks++; if (pops[0].cyc !== req_cyc[0] + 2) begin n_fail++; $display("FAIL stream_latency: got cycle %0d expected %0d", pops[0].cyc, req_cyc[0] + 2); end
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (pops[i].pc !== 32'(i * 4) || pops[i].instr !== (32'(i * 4) ^ DKEY) || pops[i].mis !== 1'b0 || pops[i].cyc !== pops[0].cyc + i) begin
          n_fail++; $display("FAIL stream_entry%0d: got pc %h instr %h cyc %0d expected pc %h instr %h cyc %0d", i, pops[i].pc, pops[i].instr, pops[i].cyc, 32'(i * 4), 32'(i * 4) ^ DKEY, pops[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    dec_ready = 1'b0;
    repeat (10) cycle();
    n_checks++; if (reqs.size() !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", reqs.size()); end
    n_checks++; if (stay !== 1'b1) begin n_fail++; $display("FAIL bp_stay: got %b expected 1", stay); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: got valid %b pc %h expected 1 00000000", dec_valid, dec_pc); end
    dec_ready = 1'b1;
    repeat (12) cycle();
    n_checks++;
    if (pops.size() < 8) begin
      n_fail++; $display("FAIL bp_resume_count: got %0d pops expected at least 8", pops.size());
    end else begin
      for (int i = 0; i < pops.size(); i++) begin
        n_checks++; if (pops[i].pc !== 32'(i * 4)) begin n_fail++; $display("FAIL bp_resume_pc%0d: got %h expected %h", i, pops[i].pc, 32'(i * 4)); end
      end
    end
  endtask

  task automatic test_mem_stall();
    do_reset(1);
    for (int k = 0; k < 20 && pc !== 32'h10; k++) cycle();
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL stall_reach_pc: got %h expected 00000010", pc); end
    for (int k = 0; k < 3; k++) begin
      imem_req_ready = 1'b0;
      #1;
      n_checks++; if (stay !== 1'b1 || pc !== 32'h10) begin n_fail++; $display("FAIL stall_hold%0d: got stay %b pc %h expected 1 00000010", k, stay, pc); end
      cycle();
    end
    imem_req_ready = 1'b1;
    #1;
    n_checks++; if (stay !== 1'b0) begin n_fail++; $display("FAIL stall_release: got stay %b expected 0", stay); end
    cycle();
    n_checks++; if (reqs.size() < 5 || reqs[reqs.size() - 1] !== 32'h10) begin n_fail++; $display("FAIL stall_req_addr: got %0d reqs expected the fifth to be 00000010", reqs.size()); end
    repeat (6) cycle();
    for (int i = 0; i < reqs.size(); i++) begin
      n_checks++; if (reqs[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL stall_req%0d: got %h expected %h", i, reqs[i], 32'(i * 4)); end
    end
  endtask

  task automatic test_flush();
    do_reset(3);
    cycle();
    cycle();
    n_checks++; if (reqs.size() !== 2) begin n_fail++; $display("FAIL flush_pre_reqs: got %0d expected 2", reqs.size()); end
    pc = 32'hAC; flush = 1'b1;
    #1;
    n_checks++; if (stay !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got stay %b req %b expected 1 0", stay, imem_req_valid); end
    cycle();
    flush = 1'b0;
    #1;
    n_checks++; if (stay !== 1'b1 || imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got stay %b req %b dv %b expected 1 0 0", stay, imem_req_valid, dec_valid); end
    repeat (10) cycle();
    n_checks++;
    if (reqs.size() < 3 || pops.size() < 1) begin
      n_fail++; $display("FAIL flush_after: got %0d reqs %0d pops expected at least 3 and 1", reqs.size(), pops.size());
    end else begin
      n_checks++; if (reqs[2] !== 32'hAC || req_cyc[2] !== req_cyc[1] + 4) begin n_fail++; $display("FAIL flush_refetch: got %h at +%0d expected 000000ac at +4", reqs[2], req_cyc[2] - req_cyc[1]); end
      n_checks++; if (pops[0].pc !== 32'hAC || pops[0].instr !== (32'hAC ^ DKEY) || pops[0].mis !== 1'b0) begin n_fail++; $display("FAIL flush_first_pop: got pc %h instr %h expected 000000ac %h", pops[0].pc, pops[0].instr, 32'hAC ^ DKEY); end
    end
  endtask

  task automatic test_misalign();
    do_reset(1);
    pc = 32'h6;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0 || stay !== 1'b0) begin n_fail++; $display("FAIL mis_accept: got req %b stay %b expected 0 0", imem_req_valid, stay); end
    repeat (3) cycle();
    n_checks++; if (reqs.size() !== 0) begin n_fail++; $display("FAIL mis_no_req: got %0d reqs expected 0", reqs.size()); end
    n_checks++;
    if (pops.size() < 2) begin
      n_fail++; $display("FAIL mis_pop_count: got %0d expected at least 2", pops.size());
    end else begin
      n_checks++; if (pops[0].pc !== 32'h6 || pops[0].instr !== NOP || pops[0].mis !== 1'b1) begin n_fail++; $display("FAIL mis_entry: got pc %h instr %h mis %b expected 00000006 %h 1", pops[0].pc, pops[0].instr, pops[0].mis, NOP); end
      n_checks++; if (pops[1].pc !== 32'hA) begin n_fail++; $display("FAIL mis_next_pc: got %h expected 0000000a", pops[1].pc); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(3);
    repeat (16) cycle();
    n_checks++; if (stay !== 1'b0) begin n_fail++; $display("FAIL b2b_stay: got %b expected 0", stay); end
    n_checks++;
    if (pops.size() < 8 || req_cyc.size() < 1) begin
      n_fail++; $display("FAIL b2b_count: got %0d pops expected at least 8", pops.size());
    end else begin
      n_checks++; if (pops[0].cyc !== req_cyc[0] + 4) begin n_fail++; $display("FAIL b2b_latency: got cycle %0d expected %0d", pops[0].cyc, req_cyc[0] + 4); end
      for (int i = 0; i < pops.size(); i++) begin
        n_checks++;
        if (pops[i].pc !== 32'(i * 4) || pops[i].cyc !== pops[0].cyc + i) begin
          n_fail++; $display("FAIL b2b_entry%0d: got pc %h cyc %0d expected %h %0d", i, pops[i].pc, pops[i].cyc, 32'(i * 4), pops[0].cyc + i);
        end
      end
    end
    n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_prereset_valid: got %b expected 1", dec_valid); end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_midreset: got dv %b req %b expected 0 0", dec_valid, imem_req_valid); end
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; pc = 32'h0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_mem_stall();
    test_flush();
    test_misalign();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Consumes the current `pc` and issues in-order word reads to instruction memory over a valid/ready request, valid-only response interface.
- Buffers returned instructions with their PC in a small queue feeding decode.
- Drives `stay` back to the PC unit so the PC holds whenever a fetch cannot be issued. Discards in-flight and buffered instructions on a branch/jump redirect.

Parameters:
- DEPTH, 4, queue entries; also the maximum outstanding plus buffered fetches; power of two, 2..16
- NOP_INSTR, 32'h00000013, instruction word substituted for a misaligned fetch

Ports:
- clk  input  1  clock, all state updates on posedge
- rstn  input  1  synchronous active-low reset
- pc  input  32  current PC from PC unit
- stay  output  1  1 = PC unit must hold `pc` this cycle (fetch not accepted)
- flush  input  1  redirect: a taken branch/jump was resolved; discard all younger fetches
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  word-aligned fetch address ({pc[31:2],2'b00})
- imem_rsp_valid  input  1  response valid; responses return in request order, latency ≥1 cycle
- imem_rsp_data  input  32  instruction word
- dec_valid  output  1  queue head valid
- dec_ready  input  1  decode accepts head
- dec_instr  output  32  head instruction
- dec_pc  output  32  head PC
- dec_misalign  output  1  head came from a pc with pc[1:0]!=0

Behaviour:
- Reset (rstn=0 at posedge):
  - queue empty, outstanding=0, drop=0, state=RUN.
  - Outputs: dec_valid=0, imem_req_valid=0, stay=1, dec_instr/dec_pc/dec_misalign=0.
- Occupancy: occ = outstanding + queued. A slot is free when occ<DEPTH, or when occ==DEPTH and a dec pop happens in the same cycle.
- FSM states RUN, DRAIN.
- RUN:
  - imem_req_valid = slot free && !flush && pc[1:0]==0.
  - Fetch accepted when imem_req_valid && imem_req_ready.
    - outstanding+1.
    - pc is pushed to an in-order tag FIFO.
  - pc[1:0]!=0 && slot free && !flush:
    - no memory request.
    - Entry {NOP_INSTR, pc, misalign=1} is enqueued directly.
    - Counts as accepted.
    - Order must be kept: enqueue only when outstanding==0, else hold (stay=1).
  - stay = !accepted (combinational). The PC unit advances only on accepted cycles.
- Response with outstanding>0 and drop==0: enqueue {imem_rsp_data, tag FIFO head, 0}; outstanding-1. Space is guaranteed by the credit rule.
- Decode pop: dec_valid && dec_ready, 1 entry/cycle. Push and pop can occur in the same cycle. dec_* are registered from the head with zero bubble on back-to-back pops.
- flush in RUN (same cycle):
  - queue cleared; no request issued that cycle; drop := outstanding minus any response arriving that cycle.
  - Next state DRAIN if drop>0, else RUN.
  - stay=1 during the flush cycle so the redirected PC is held.
- DRAIN:
  - imem_req_valid=0, stay=1, dec_valid=0.
  - Each imem_rsp_valid decrements drop and its data is discarded.
  - drop reaches 0 → RUN next cycle.
  - flush in DRAIN: ignored, already draining.
- imem_rsp_valid with outstanding==0 and drop==0 is a protocol error and is ignored (no state change).
- Reset mid-operation: all in-flight requests are forgotten. Late memory responses after reset are the memory's responsibility to squash; the bench keeps the memory in reset too.
- Counters are $clog2(DEPTH)+1 bits wide; they never wrap under legal use.
- Latency: pc accepted at cycle N with memory latency L gives dec_valid at N+L+1.

Test Plan:
- Reset then stream: memory latency 1, always ready, dec_ready=1, pc steps 0,4,8,... → dec_pc 0x0,0x4,0x8 on consecutive cycles, first dec_valid 2 cycles after first accept, stay=0 in steady state.
- Backpressure: dec_ready=0 with DEPTH=4 → exactly 4 requests issued, then stay=1 and imem_req_valid=0. Raising dec_ready resumes the stream with no lost or duplicated PC.
- Memory stall: imem_req_ready=0 for 3 cycles → stay=1 those 3 cycles and pc is held (e.g. 0x10). The request for 0x10 is issued on the first ready cycle.
- Flush with 2 outstanding (latency 3), pc redirected to 0xAC → 2 responses discarded, no dec_valid for them, then the fetch of 0xAC issues and dec_pc=0xAC with matching data.
- Misaligned pc=0x6 with queue idle → dec_instr=0x00000013, dec_misalign=1, dec_pc=0x6, no imem request.
- Simultaneous push/pop at full occupancy → queue stays full, throughput 1/cycle, and synchronous reset asserted mid-stream clears dec_valid at the next edge.
